// File: rtl/crc_frame_ctrl_if.sv
// rtl/crc_frame_ctrl_if.sv - byte input, CRC engine and result signal bundle for crc_frame_ctrl
interface crc_frame_ctrl_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       abort;
  logic       crc_clr;
  logic       crc_en;
  logic       crc_bit;
  logic [7:0] crc_value;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_crc;
  logic       res_match;
  logic [7:0] res_len;
  logic       err_overrun;

  modport slave (
    input  in_valid, in_data, in_last, abort, crc_value, res_ready,
    output in_ready, crc_clr, crc_en, crc_bit, res_valid, res_crc, res_match, res_len,
           err_overrun
  );

  modport master (
    output in_valid, in_data, in_last, abort, crc_value, res_ready,
    input  in_ready, crc_clr, crc_en, crc_bit, res_valid, res_crc, res_match, res_len,
           err_overrun
  );
endinterface

// File: rtl/crc_frame_ctrl.sv
// rtl/crc_frame_ctrl.sv - frame sequencer feeding a bit-serial CRC-8 engine, with result port
module crc_frame_ctrl #(
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned MAX_LEN   = 255
) (
  input logic            clk,
  input logic            reset,
  crc_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, WAIT, RESULT} state_t;

  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

  state_t     state, state_n;
  logic [7:0] byte_q, byte_n;
  logic       last_q, last_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] len_q, len_n;

  logic       crc_clr_q, crc_en_q, crc_bit_q;
  logic       res_valid_q, res_match_q, err_q;
  logic [7:0] res_crc_q, res_len_q;

  logic       accept, overrun, load_res;
  logic [7:0] res_crc_n, final_crc;

  function automatic logic sel_bit(input logic [7:0] b, input logic [2:0] idx);
    return MSB_FIRST ? b[idx] : b[3'd7 - idx];
  endfunction

  // The engine only commits the last bit at the edge closing SHIFT, so its
  // post-update value is formed here to present a registered result on time.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
    return {c[6:0], 1'b0} ^ ((c[7] ^ d) ? 8'h1D : 8'h00);
  endfunction

  assign bus.in_ready = ((state == IDLE) || (state == WAIT)) && !bus.abort;
  assign accept       = bus.in_valid && bus.in_ready;
  assign final_crc    = crc_step(bus.crc_value, crc_bit_q);

  always_comb begin
    state_n   = state;
    byte_n    = byte_q;
    last_n    = last_q;
    bit_cnt_n = bit_cnt;
    len_n     = len_q;
    load_res  = 1'b0;
    overrun   = 1'b0;
    res_crc_n = bus.crc_value;
    if (bus.abort && (state != IDLE)) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            byte_n    = bus.in_data;
            last_n    = bus.in_last;
            len_n     = 8'd1;
            bit_cnt_n = 3'd7;
            state_n   = CLR;
          end
        end
        CLR: begin
          bit_cnt_n = 3'd7;
          state_n   = SHIFT;
        end
        SHIFT: begin
          if (bit_cnt == 3'd0) begin
            if (last_q) begin
              state_n   = RESULT;
              load_res  = 1'b1;
              res_crc_n = final_crc;
            end else begin
              state_n = WAIT;
            end
          end else begin
            bit_cnt_n = bit_cnt - 3'd1;
          end
        end
        WAIT: begin
          if (accept) begin
            if ((len_q == LEN_MAX) && !bus.in_last) begin
              // Engine already holds the CRC of the kept bytes; the extra byte is dropped.
              overrun  = 1'b1;
              load_res = 1'b1;
              state_n  = RESULT;
            end else begin
              byte_n    = bus.in_data;
              last_n    = bus.in_last;
              len_n     = (len_q == LEN_MAX) ? len_q : len_q + 8'd1;
              bit_cnt_n = 3'd7;
              state_n   = SHIFT;
            end
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      byte_q      <= 8'h00;
      last_q      <= 1'b0;
      bit_cnt     <= 3'd0;
      len_q       <= 8'h00;
      crc_clr_q   <= 1'b0;
      crc_en_q    <= 1'b0;
      crc_bit_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_crc_q   <= 8'h00;
      res_match_q <= 1'b0;
      res_len_q   <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      byte_q      <= byte_n;
      last_q      <= last_n;
      bit_cnt     <= bit_cnt_n;
      len_q       <= len_n;
      crc_clr_q   <= (state_n == CLR) || (bus.abort && (state != IDLE));
      crc_en_q    <= (state_n == SHIFT);
      crc_bit_q   <= (state_n == SHIFT) ? sel_bit(byte_n, bit_cnt_n) : 1'b0;
      res_valid_q <= (state_n == RESULT);
      if (load_res) begin
        res_crc_q   <= res_crc_n;
        res_match_q <= (res_crc_n == 8'h00);
        res_len_q   <= len_q;
      end
      if (overrun) begin
        err_q <= 1'b1;
      end else if ((state == IDLE) && accept) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.crc_clr     = crc_clr_q;
  assign bus.crc_en      = crc_en_q;
  assign bus.crc_bit     = crc_bit_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_crc     = res_crc_q;
  assign bus.res_match   = res_match_q;
  assign bus.res_len     = res_len_q;
  assign bus.err_overrun = err_q;

endmodule
